// File: rtl/sequential_mac.sv
// Shift-add sequential multiplier with optional accumulate into a guarded accumulator.
// One partial product per cycle; start/busy/done handshake; unsigned or two's complement.
module sequential_mac #(
    parameter int p_data_width = 8,
    parameter int p_guard_bits = 8
) (
    input  logic                                     i_w_clk,
    input  logic                                     i_w_reset,
    input  logic [p_data_width-1:0]                  i_w_a,
    input  logic [p_data_width-1:0]                  i_w_b,
    input  logic                                     i_w_start,
    input  logic                                     i_w_signed,
    input  logic                                     i_w_accumulate,
    input  logic                                     i_w_clear,
    output logic                                     o_w_busy,
    output logic                                     o_w_done,
    output logic [2*p_data_width+p_guard_bits-1:0]   o_w_out
);

    localparam int W  = p_data_width;
    localparam int AW = 2 * p_data_width + p_guard_bits;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_mag_q, a_mag_d;
    logic [W-1:0]    b_shift_q, b_shift_d;
    logic [2*W-1:0]  partial_q, partial_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            signed_q, signed_d;
    logic            accum_q, accum_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            done_q, done_d;

    logic [W-1:0]    a_abs, b_abs;
    logic [2*W-1:0]  addend;
    logic [2*W-1:0]  prod_2w;
    logic [AW-1:0]   prod_ext;

    // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        a_mag_d   = a_mag_q;
        b_shift_d = b_shift_q;
        partial_d = partial_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        signed_d  = signed_q;
        accum_d   = accum_q;
        acc_d     = acc_q;
        done_d    = 1'b0;

        // Magnitude of the most-negative value still fits in W unsigned bits.
        a_abs    = (i_w_signed && i_w_a[W-1]) ? -i_w_a : i_w_a;
        b_abs    = (i_w_signed && i_w_b[W-1]) ? -i_w_b : i_w_b;
        addend   = (2 * W)'(a_mag_q) << cnt_q;
        prod_2w  = neg_q ? -partial_q : partial_q;
        prod_ext = signed_q ? AW'($signed(prod_2w)) : AW'(prod_2w);

        unique case (state_q)
            S_IDLE: begin
                if (i_w_start) begin
                    signed_d  = i_w_signed;
                    accum_d   = i_w_accumulate;
                    a_mag_d   = a_abs;
                    b_shift_d = b_abs;
                    neg_d     = i_w_signed & (i_w_a[W-1] ^ i_w_b[W-1]);
                    partial_d = '0;
                    cnt_d     = '0;
                    state_d   = S_RUN;
                end else if (i_w_clear) begin
                    acc_d = '0;
                end
            end
            S_RUN: begin
                if (b_shift_q[0]) begin
                    partial_d = partial_q + addend;
                end
                b_shift_d = b_shift_q >> 1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                acc_d   = accum_q ? acc_q + prod_ext : prod_ext;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments only; reset is synchronous and clears every register.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            state_q   <= S_IDLE;
            a_mag_q   <= '0;
            b_shift_q <= '0;
            partial_q <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            signed_q  <= 1'b0;
            accum_q   <= 1'b0;
            acc_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_mag_q   <= a_mag_d;
            b_shift_q <= b_shift_d;
            partial_q <= partial_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            signed_q  <= signed_d;
            accum_q   <= accum_d;
            acc_q     <= acc_d;
            done_q    <= done_d;
        end
    end

    assign o_w_busy = (state_q != S_IDLE);
    assign o_w_done = done_q;
    assign o_w_out  = acc_q;

endmodule

// File: tb/tb_sequential_mac.sv
// Directed bench for sequential_mac (W=8, G=8): handshake timing, signed/unsigned
// products, accumulate/clear, ignored inputs while busy, mid-run reset, wraparound.
module tb_sequential_mac;

    localparam int W  = 8;
    localparam int G  = 8;
    localparam int AW = 2 * W + G;

    logic          clk;
    logic          rst;
    logic [W-1:0]  a, b;
    logic          start, sg, ac, clr;
    logic          busy, done;
    logic [AW-1:0] out;

    int            n_vec = 0;
    int            n_err = 0;
    logic [AW-1:0] acc_m;

    sequential_mac #(.p_data_width(W), .p_guard_bits(G)) dut (
        .i_w_clk        (clk),
        .i_w_reset      (rst),
        .i_w_a          (a),
        .i_w_b          (b),
        .i_w_start      (start),
        .i_w_signed     (sg),
        .i_w_accumulate (ac),
        .i_w_clear      (clr),
        .o_w_busy       (busy),
        .o_w_done       (done),
        .o_w_out        (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] prod_m(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
        int p;
        if (s) p = int'($signed(x)) * int'($signed(y));
        else   p = int'(x) * int'(y);
        return p[AW-1:0];
    endfunction

    // Issue one start, then watch W+3 sample points (start edge +0 .. +W+2).
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xs, input logic xac,
                         output int busy_cnt, output int done_cnt, output int done_at);
        a = xa; b = xb; sg = xs; ac = xac; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i <= W + 2; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
        end
        acc_m = xac ? acc_m + prod_m(xa, xb, xs) : prod_m(xa, xb, xs);
    endtask

    initial begin
        int bc, dc, da;
        longint wrap_exp;

        rst = 1'b1; a = '0; b = '0; start = 1'b0; sg = 1'b0; ac = 1'b0; clr = 1'b0;
        acc_m = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_out", 32'(out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // Basic handshake timing.
        do_op(8'd2, 8'd4, 1'b0, 1'b0, bc, dc, da);
        check("t1_busy_cycles", 32'(bc), 32'd9);
        check("t1_done_count", 32'(dc), 32'd1);
        check("t1_done_edge", 32'(da), 32'd9);
        check("t1_out", 32'(out), 32'd8);

        do_op(8'd255, 8'd255, 1'b0, 1'b0, bc, dc, da);
        check("u255x255", 32'(out), 32'h00FE01);
        do_op(8'hFD, 8'd5, 1'b1, 1'b0, bc, dc, da);
        check("s_m3x5", 32'(out), 32'hFFFFF1);
        do_op(8'h80, 8'h80, 1'b1, 1'b0, bc, dc, da);
        check("s_m128xm128", 32'(out), 32'd16384);

        // Accumulate chain and clear.
        do_op(8'd3, 8'd4, 1'b0, 1'b0, bc, dc, da);
        check("acc_12", 32'(out), 32'd12);
        do_op(8'd5, 8'd6, 1'b0, 1'b1, bc, dc, da);
        check("acc_42", 32'(out), 32'd42);
        do_op(8'hFE, 8'd10, 1'b1, 1'b1, bc, dc, da);
        check("acc_22", 32'(out), 32'd22);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clear_idle", 32'(out), 32'd0);
        acc_m = '0;

        // Start/clear toggled while busy must be ignored.
        a = 8'd2; b = 8'd4; sg = 1'b0; ac = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dc = 0;
        for (int i = 1; i <= W + 4; i++) begin
            @(posedge clk); #1;
            if (done) dc++;
            if (i <= W) begin
                start = i[0]; clr = ~i[0]; a = 8'd7; b = 8'd7;
            end else begin
                start = 1'b0; clr = 1'b0;
            end
        end
        check("busy_ignore_out", 32'(out), 32'd8);
        check("busy_ignore_done", 32'(dc), 32'd1);

        // Start and clear together in IDLE: start wins, accumulator kept.
        a = 8'd1; b = 8'd1; ac = 1'b1; start = 1'b1; clr = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clr = 1'b0;
        check("start_clr_no_clear", 32'(out), 32'd8);
        check("start_clr_busy", 32'(busy), 32'd1);
        repeat (W + 1) @(posedge clk);
        #1;
        check("start_clr_out", 32'(out), 32'd9);

        // Reset during the 4th RUN cycle.
        a = 8'd100; b = 8'd100; ac = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        dc = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk); #1;
            if (done) dc++;
        end
        check("midrst_no_done", 32'(dc), 32'd0);
        do_op(8'd6, 8'd7, 1'b0, 1'b0, bc, dc, da);
        check("after_rst_42", 32'(out), 32'd42);

        // Wraparound of the 24-bit accumulator.
        do_op(8'd255, 8'd255, 1'b0, 1'b0, bc, dc, da);
        check("wrap_preload", 32'(out), 32'(acc_m));
        for (int n = 1; n <= 259; n++) begin
            do_op(8'd255, 8'd255, 1'b0, 1'b1, bc, dc, da);
            check($sformatf("wrap%0d", n), 32'(out), 32'(acc_m));
        end
        wrap_exp = (64'd65025 * 64'd260) % 64'd16777216;
        check("wrap_final", 32'(out), 32'(wrap_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
